// File: rtl/edge_event_recorder.sv
// Edge event recorder: stamps every change on the monitored channels with a
// free-running cycle count and queues the records in a first-word-fall-through FIFO.
module edge_event_recorder #(
  parameter int NUM_CH   = 4,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [NUM_CH-1:0]          ch_in,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [NUM_CH-1:0]          evt_mask,
  output logic [NUM_CH-1:0]          evt_level,
  output logic [TS_WIDTH-1:0]        evt_time,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 2 * NUM_CH + TS_WIDTH;

  logic [TS_WIDTH-1:0] ts_r;
  logic [NUM_CH-1:0]   prev_r;
  logic                armed_r;
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic                valid_r;
  logic                overflow_r;
  logic [RW-1:0]       head_r;
  logic [RW-1:0]       mem_r [DEPTH];

  logic [NUM_CH-1:0]   diff_s;
  logic [RW-1:0]       rec_s;
  logic                full_s;
  logic                pop_s;
  logic                push_req_s;
  logic                push_ok_s;
  logic                drop_s;
  logic [CW-1:0]       count_nxt_s;
  logic [PW-1:0]       rd_nxt_s;
  logic [RW-1:0]       head_nxt_s;

  // Change detection, FIFO handshake and the next head record
  always_comb begin
    diff_s      = ch_in ^ prev_r;
    rec_s       = {diff_s, ch_in, ts_r};
    full_s      = (count_r == CW'(DEPTH));
    pop_s       = valid_r & evt_ready;
    push_req_s  = enable & armed_r & (|diff_s) & ~clear;
    push_ok_s   = push_req_s & (~full_s | pop_s);
    drop_s      = push_req_s & full_s & ~pop_s;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      rd_nxt_s = rd_ptr_r + PW'(1);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    // A record written into the slot that becomes the head bypasses the array
    if (count_nxt_s == CW'(0)) begin
      head_nxt_s = '0;
    end else if (push_ok_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = rec_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= rec_s;
    end
  end

  // Control state, timestamp and registered head outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_r       <= '0;
      prev_r     <= '0;
      armed_r    <= 1'b0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      head_r     <= '0;
    end else begin
      prev_r <= ch_in;
      if (clear) begin
        ts_r       <= '0;
        armed_r    <= 1'b0;
        wr_ptr_r   <= '0;
        rd_ptr_r   <= '0;
        count_r    <= '0;
        valid_r    <= 1'b0;
        overflow_r <= 1'b0;
        head_r     <= '0;
      end else begin
        armed_r  <= 1'b1;
        if (enable) begin
          ts_r <= ts_r + TS_WIDTH'(1);
        end
        if (push_ok_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
        rd_ptr_r <= rd_nxt_s;
        count_r  <= count_nxt_s;
        valid_r  <= (count_nxt_s != CW'(0));
        head_r   <= head_nxt_s;
      end
    end
  end

  assign evt_valid = valid_r;
  assign evt_count = count_r;
  assign overflow  = overflow_r;
  assign evt_mask  = head_r[RW-1 -: NUM_CH];
  assign evt_level = head_r[TS_WIDTH +: NUM_CH];
  assign evt_time  = head_r[TS_WIDTH-1:0];

endmodule
